// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO registers; divide datapath enabled by `define MDU_DIV_EN
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             In_Start,
   input  logic [2:0]       In_Op,
   input  logic [WIDTH-1:0] In_A,
   input  logic [WIDTH-1:0] In_B,
   input  logic             In_Read_Sel,
   output logic             Out_Busy,
   output logic             Out_Done,
   output logic [WIDTH-1:0] Out_Data,
   output logic             Out_Illegal
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] hi, lo, ma, mag_a, mag_b;
   logic [2*WIDTH-1:0] p, p_nxt, res;
   logic [WIDTH:0] add_sum;
   logic [CW-1:0] cnt;
   logic neg_q, accept, op_mul, op_div, op_legal, sgn, sa, sb;
`ifdef MDU_DIV_EN
   logic [WIDTH-1:0] mb, a_raw;
   logic [WIDTH:0] r1, diff;
   logic neg_r, is_div;
`endif
   assign accept = In_Start && state == IDLE;
   assign op_mul = In_Op[2:1] == 2'b00;
`ifdef MDU_DIV_EN
   assign op_div = In_Op[2:1] == 2'b01;
`else
   assign op_div = 1'b0;
`endif
   assign op_legal = op_mul || op_div || In_Op[2:1] == 2'b10;
   assign sgn = !In_Op[0];
   assign sa = sgn && In_A[WIDTH-1];
   assign sb = sgn && In_B[WIDTH-1];
   assign mag_a = sa ? -In_A : In_A;
   assign mag_b = sb ? -In_B : In_B;
   assign Out_Busy = state != IDLE;
   assign Out_Data = In_Read_Sel ? hi : lo;
   // next-state: iterate WIDTH cycles, one fixup cycle, then back to idle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !accept ? IDLE : op_mul ? MUL : op_div ? DIV : IDLE;
         MUL,
         DIV:     state_nxt = cnt == CW'(WIDTH-1) ? FIXUP : state;
         default: state_nxt = IDLE;
      endcase
   end
   // one shift-add / restoring shift-subtract step, and the sign-corrected result
   always_comb begin
      add_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, ma} : '0);
`ifdef MDU_DIV_EN
      r1 = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      diff = r1 - {1'b0, mb};
      p_nxt = state == MUL ? {add_sum, p[WIDTH-1:1]} :
              diff[WIDTH] ? {r1[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      res = !is_div ? (neg_q ? -p : p) :
            mb == '0 ? {a_raw, {WIDTH{1'b1}}} :
            {neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH], neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0]};
`else
      p_nxt = {add_sum, p[WIDTH-1:1]};
      res = neg_q ? -p : p;
`endif
   end
   // state, operand latches, iteration registers and HI/LO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hi <= '0;
         lo <= '0;
         ma <= '0;
         p <= '0;
         cnt <= '0;
         neg_q <= 1'b0;
         Out_Done <= 1'b0;
         Out_Illegal <= 1'b0;
`ifdef MDU_DIV_EN
         mb <= '0;
         a_raw <= '0;
         neg_r <= 1'b0;
         is_div <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         Out_Done <= state == FIXUP;
         Out_Illegal <= accept && !op_legal;
         if (accept && (op_mul || op_div)) begin
            ma <= mag_a;
            p <= {{WIDTH{1'b0}}, op_mul ? mag_b : mag_a};
            cnt <= '0;
            neg_q <= sa ^ sb;
`ifdef MDU_DIV_EN
            mb <= mag_b;
            a_raw <= In_A;
            neg_r <= sa;
            is_div <= op_div;
`endif
         end else if (state == MUL || state == DIV) begin
            p <= p_nxt;
            cnt <= cnt + CW'(1);
         end
         if (accept && In_Op == 3'b100) hi <= In_A;
         if (accept && In_Op == 3'b101) lo <= In_A;
         if (state == FIXUP) {hi, lo} <= res;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
   localparam int W = 32;
   logic clk = 1'b0, rst = 1'b1, in_start = 1'b0, in_read_sel = 1'b0;
   logic [2:0] in_op = 3'd0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic out_busy, out_done, out_illegal;
   logic [W-1:0] out_data;
   typedef struct {
      int unsigned due;
      int kind;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } item_t;
   item_t sb[$];
   int unsigned cyc = 0, next_free = 0;
   int n_tests = 0, n_fail = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0, cur_hi = '0, cur_lo = '0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .In_Start(in_start), .In_Op(in_op), .In_A(in_a), .In_B(in_b),
      .In_Read_Sel(in_read_sel), .Out_Busy(out_busy), .Out_Done(out_done), .Out_Data(out_data),
      .Out_Illegal(out_illegal)
   );

   always #5 clk = ~clk;
   // cycle counter shared by stimulus and monitor
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // monitor: pops the scoreboard when an event is due and checks every visible output
   always @(negedge clk) begin
      item_t it;
      logic e_done, e_ill, e_busy;
      e_done = 1'b0;
      e_ill = 1'b0;
      e_busy = 1'b0;
      if (rst) begin
         cur_hi = '0;
         cur_lo = '0;
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         it = sb.pop_front();
         if (it.due != cyc) check("event_lost", W'(it.due), W'(cyc));
         e_done = it.kind == 1;
         e_ill = it.kind == 2;
         cur_hi = it.hi;
         cur_lo = it.lo;
      end
      if (!rst && sb.size() > 0 && sb[0].kind == 1 && cyc + W + 1 >= sb[0].due) e_busy = 1'b1;
      check("done", W'(out_done), W'(e_done));
      check("illegal", W'(out_illegal), W'(e_ill));
      check("busy", W'(out_busy), W'(e_busy));
      check(in_read_sel ? "data_hi" : "data_lo", out_data, in_read_sel ? cur_hi : cur_lo);
   end

   function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 1;
         2: return '1;
         3: return {1'b1, {(W-1){1'b0}}};
         4: return W'($urandom_range(0, 15));
         default: return W'($urandom());
      endcase
   endfunction

   // reference model: expected HI/LO and event kind for a request accepted in idle
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int kind);
      int ia, ib;
      longint x, y;
      logic [2*W-1:0] prod;
      ia = a;
      ib = b;
      kind = 1;
      case (op)
         3'd0: begin
            x = ia;
            y = ib;
            prod = x * y;
            {m_hi, m_lo} = prod;
         end
         3'd1: begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            {m_hi, m_lo} = prod;
         end
`ifdef MDU_DIV_EN
         3'd2: begin
            if (b == 0) begin m_hi = a; m_lo = '1; end
            else if (a == 32'h80000000 && b == 32'hffffffff) begin m_hi = 0; m_lo = a; end
            else begin m_lo = ia / ib; m_hi = ia % ib; end
         end
         3'd3: begin
            if (b == 0) begin m_hi = a; m_lo = '1; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
`endif
         3'd4: begin m_hi = a; kind = 0; end
         3'd5: begin m_lo = a; kind = 0; end
         default: kind = 2;
      endcase
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit run_out);
      int kind;
      item_t it;
      while (cyc < next_free) @(posedge clk) #1;
      in_start = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_read_sel = 1'($urandom());
      model(op, a, b, kind);
      it.due = kind == 1 ? cyc + W + 2 : cyc + 1;
      it.kind = kind;
      it.hi = m_hi;
      it.lo = m_lo;
      sb.push_back(it);
      next_free = it.due == cyc + 1 ? cyc + 1 : it.due;
      @(posedge clk) #1;
      in_start = 1'b0;
      while (run_out && cyc < next_free) begin
         in_start = 1'($urandom_range(0, 3) == 0);
         in_op = 3'($urandom());
         in_a = W'($urandom());
         in_b = W'($urandom());
         in_read_sel = 1'($urandom());
         @(posedge clk) #1;
      end
      in_start = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      next_free = cyc;
      issue(3'd1, 32'hffffffff, 32'hffffffff, 1);
      issue(3'd0, 32'hfffffffd, 32'h00000007, 1);
      issue(3'd2, 32'hfffffff9, 32'h00000002, 1);
      issue(3'd3, 32'd100, 32'd0, 1);
      issue(3'd2, 32'h80000000, 32'hffffffff, 1);
      issue(3'd4, 32'h12345678, 32'h0, 1);
      in_read_sel = 1'b1;
      @(posedge clk) #1;
      issue(3'd6, 32'hdeadbeef, 32'h1, 1);
      issue(3'd7, 32'hcafef00d, 32'h2, 1);
      issue(3'd5, 32'h0badcafe, 32'h0, 1);
      for (int i = 0; i < 60; i++) begin
         issue(3'($urandom()), rnd(), rnd(), 1);
         repeat ($urandom_range(0, 2)) @(posedge clk) #1;
      end
      issue(3'd0, 32'h00001234, 32'hffff0000, 0);
      repeat (9) @(posedge clk) #1;
      sb.delete();
      rst = 1'b1;
      #2;
      check("rst_busy", W'(out_busy), W'(0));
      check("rst_data", out_data, '0);
      @(posedge clk) #1;
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      next_free = cyc;
      repeat (W + 4) @(posedge clk) #1;
      issue(3'd2, 32'h00000064, 32'h00000007, 1);
      issue(3'd1, 32'h00010001, 32'h0000ffff, 1);
      repeat (W + 4) @(posedge clk) #1;
      check("drain", W'(sb.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width; SHALL be even and >= 8.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 In_Start  input  1  operation request, sampled on rising clk.
REQ-005 In_Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 In_A  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-007 In_B  input  WIDTH  multiplier / divisor.
REQ-008 In_Read_Sel  input  1  0 selects LO, 1 selects HI onto Out_Data.
REQ-009 Out_Busy  output  1  iterative operation in progress.
REQ-010 Out_Done  output  1  one-cycle pulse: new HI/LO now visible.
REQ-011 Out_Data  output  WIDTH  HI or LO, feeding the write-back select path.
REQ-012 Out_Illegal  output  1  one-cycle pulse: request rejected (see REQ-031).

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIXUP; encoding free.
REQ-014 Request accepted only in IDLE with In_Start=1; In_A, In_B, In_Op latched at the accepting edge.
REQ-015 In_Start while Out_Busy=1 SHALL be ignored with no state or output change.
REQ-016 MULT/MULTU: IDLE->MUL; WIDTH shift-add iterations on operand magnitudes, then FIXUP, then IDLE.
REQ-017 DIV/DIVU: IDLE->DIV; WIDTH restoring shift-subtract iterations on magnitudes, then FIXUP, then IDLE.
REQ-018 FIXUP SHALL apply sign correction for signed ops and write HI/LO at its closing edge.
REQ-019 Out_Busy SHALL be high for exactly WIDTH+1 cycles starting the cycle after acceptance.
REQ-020 Out_Done SHALL be high for exactly one cycle, the cycle after the last Busy cycle; Out_Busy=0 in that cycle.
REQ-021 A new request MAY be accepted in the Out_Done cycle.
REQ-022 Multiply: {HI,LO} = full 2*WIDTH-bit product, two's-complement for MULT, unsigned for MULTU.
REQ-023 Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-024 Divide by zero: HI = latched In_A, LO = all ones; same latency, no error pulse.
REQ-025 Signed overflow (most-negative / -1): LO = most-negative value, HI = 0.
REQ-026 MTHI/MTLO: write In_A to HI/LO at accepting edge; no Busy, no Done; new value visible next cycle.
REQ-027 Reserved In_Op: request ignored, state and HI/LO unchanged, Out_Illegal pulsed one cycle.
REQ-028 Out_Data combinational from HI/LO per In_Read_Sel; HI/LO SHALL hold old values throughout Busy.

Reset
REQ-029 rst=1 SHALL force IDLE, HI=0, LO=0, Out_Busy=0, Out_Done=0, Out_Illegal=0, clearing all iteration registers, independent of clk.
REQ-030 Reset mid-operation SHALL abort it; no Done pulse and no HI/LO update after release.

Configuration
REQ-031 Macro MDU_DIV_EN: defined -> DIV/DIVU per REQ-017/023-025; undefined -> no divide datapath is synthesised, DIV/DIVU treated as reserved per REQ-027 (Out_Illegal pulse, HI/LO unchanged).
REQ-032 MULT, MULTU, MTHI, MTLO behaviour SHALL be identical in both configurations.

Verification
REQ-033 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy 33 cycles, Done cycle 34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 MULT A=0xFFFFFFFD (-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; Start asserted mid-Busy ignored.
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100, B=0 -> HI=100, LO=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 MTHI A=0x12345678 then Read_Sel=1 next cycle -> Out_Data=0x12345678, Busy and Done stay 0; In_Op=110 -> Out_Illegal pulse, HI/LO unchanged.
REQ-037 rst asserted at cycle 10 of a MULT -> immediate IDLE, HI=LO=0, no Done; macro undefined, DIV request -> Out_Illegal pulse, Busy stays 0.
